// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder bridging byte commands onto an 8-bit register file
module spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte, tx_shift;
  logic       is_read, re_next, miso_q;
  logic       shifting, byte_done;
  logic       cmd_done, cmd_bad, addr_done, wdata_done, rdata_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  // cs sync resets low, so a cs_n held low across reset release never looks like a fall
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  assign shifting   = (state inside {CMD, ADDR, WDATA, RDATA}) && !cs_s;
  assign byte_done  = shifting && sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte    = {rx_shift, mosi_s};
  assign cmd_done   = byte_done && (state == CMD);
  assign cmd_bad    = cmd_done && (rx_byte != CMD_WRITE) && (rx_byte != CMD_READ);
  assign addr_done  = byte_done && (state == ADDR);
  assign wdata_done = byte_done && (state == WDATA);
  assign rdata_done = byte_done && (state == RDATA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = CMD;
      CMD:     if (byte_done) state_next = cmd_bad ? IGNORE : ADDR;
      ADDR:    if (byte_done) state_next = is_read ? RDATA : WDATA;
      default: state_next = state;
    endcase
    // a deselected bus always wins, including over a byte finishing this cycle
    if (state != IDLE && cs_s) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'd0;
      is_read     <= 1'b0;
      re_next     <= 1'b0;
      miso_q      <= 1'b0;
      reg_addr_o  <= 8'h00;
      reg_wdata_o <= 8'h00;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      cmd_err_o   <= 1'b0;
    end else begin
      cmd_err_o <= cmd_bad;
      reg_we_o  <= wdata_done;
      reg_re_o  <= (addr_done && is_read) || (re_next && !cs_s);
      re_next   <= rdata_done;

      if (state == IDLE) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 7'd0;
      end else if (shifting && sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte[6:0];
      end

      if (cmd_done) is_read <= (rx_byte == CMD_READ);
      if (wdata_done) reg_wdata_o <= rx_byte;

      // the write address advances the cycle after its strobe; reads advance before prefetch
      if (addr_done) reg_addr_o <= rx_byte;
      else if (reg_we_o || rdata_done) reg_addr_o <= reg_addr_o + 8'd1;

      if (reg_re_o) begin
        tx_shift <= reg_rdata_i;
      end else if (state == RDATA && shifting && sclk_fall) begin
        miso_q   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (state != RDATA) miso_q <= 1'b0;
    end
  end

  assign busy_o    = (state != IDLE);
  assign miso_oe_o = (state == RDATA) && !cs_s;
  assign miso_o    = miso_oe_o & miso_q;

endmodule
